// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encodings and port indices for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACCESS = 2'b01,
        ARB_DONE   = 2'b10
    } arb_state_e;

    localparam logic ARB_P0 = 1'b0;
    localparam logic ARB_P1 = 1'b1;

endpackage

// File: rtl/arb_priority_sel.sv
// rtl/arb_priority_sel.sv - combinational winner select: port 0 first unless port 1 is starved
module arb_priority_sel
    import mem_port_arbiter_pkg::*;
(
    input  logic p0_req_i,
    input  logic p1_req_i,
    input  logic starve_i,
    output logic any_req_o,
    output logic winner_o
);

    assign any_req_o = p0_req_i | p1_req_i;
    assign winner_o  = (p1_req_i && (!p0_req_i || starve_i)) ? ARB_P1 : ARB_P0;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port fixed-latency memory arbiter; ARB_STATS_EN adds grant counters and STARVED
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 26,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              P0_REQ,
    input  logic              P0_WE,
    input  logic [ADDR_W-1:0] P0_ADDR,
    input  logic [DATA_W-1:0] P0_WDATA,
    output logic              P0_GNT,
    output logic              P0_ACK,
    output logic [DATA_W-1:0] P0_RDATA,
    input  logic              P1_REQ,
    input  logic              P1_WE,
    input  logic [ADDR_W-1:0] P1_ADDR,
    input  logic [DATA_W-1:0] P1_WDATA,
    output logic              P1_GNT,
    output logic              P1_ACK,
    output logic [DATA_W-1:0] P1_RDATA,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       P0_GRANTS,
    output logic [15:0]       P1_GRANTS,
    output logic              STARVED
`endif
);

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state_q;
    logic              owner_q;
    logic              we_q;
    logic [LAT_W-1:0]  lat_q;
    logic [SW-1:0]     starve_q;
    logic [SW-1:0]     starve_d;
    logic [DATA_W-1:0] rdata_q;
    logic              starve_full;
    logic              any_req;
    logic              winner;
    logic              sel_we;

    assign starve_full = (starve_q == SW'(STARVE_LIMIT));
    assign sel_we      = (winner == ARB_P1) ? P1_WE : P0_WE;

    arb_priority_sel u_sel (
        .p0_req_i  (P0_REQ),
        .p1_req_i  (P1_REQ),
        .starve_i  (starve_full),
        .any_req_o (any_req),
        .winner_o  (winner)
    );

    // A port-0 grant only counts against port 1 while port 1 is actually waiting.
    always_comb begin
        starve_d = '0;
        if (winner == ARB_P0 && P1_REQ) begin
            starve_d = starve_full ? starve_q : starve_q + SW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ARB_IDLE;
            owner_q   <= ARB_P0;
            we_q      <= 1'b0;
            lat_q     <= '0;
            starve_q  <= '0;
            rdata_q   <= '0;
            P0_GNT    <= 1'b0;
            P1_GNT    <= 1'b0;
            P0_ACK    <= 1'b0;
            P1_ACK    <= 1'b0;
            P0_RDATA  <= '0;
            P1_RDATA  <= '0;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    P0_ACK <= 1'b0;
                    P1_ACK <= 1'b0;
                    if (any_req) begin
                        owner_q   <= winner;
                        we_q      <= sel_we;
                        MEM_ADDR  <= (winner == ARB_P1) ? P1_ADDR : P0_ADDR;
                        MEM_WDATA <= (winner == ARB_P1) ? P1_WDATA : P0_WDATA;
                        P0_GNT    <= (winner == ARB_P0);
                        P1_GNT    <= (winner == ARB_P1);
                        MEM_READ  <= ~sel_we;
                        MEM_WRITE <= sel_we;
                        lat_q     <= LAT_W'(MEM_LATENCY - 1);
                        starve_q  <= starve_d;
                        state_q   <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    if (lat_q == '0) begin
                        if (!we_q) begin
                            rdata_q <= MEM_RDATA;
                        end
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        state_q   <= ARB_DONE;
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                ARB_DONE: begin
                    P0_GNT <= 1'b0;
                    P1_GNT <= 1'b0;
                    P0_ACK <= (owner_q == ARB_P0);
                    P1_ACK <= (owner_q == ARB_P1);
                    if (!we_q && owner_q == ARB_P0) begin
                        P0_RDATA <= rdata_q;
                    end
                    if (!we_q && owner_q == ARB_P1) begin
                        P1_RDATA <= rdata_q;
                    end
                    state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic forced;
    assign forced = P0_REQ & P1_REQ & starve_full;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            P0_GRANTS <= '0;
            P1_GRANTS <= '0;
            STARVED   <= 1'b0;
        end else begin
            STARVED <= 1'b0;
            if (state_q == ARB_IDLE && any_req) begin
                if (winner == ARB_P1) begin
                    P1_GRANTS <= P1_GRANTS + 16'd1;
                end else begin
                    P0_GRANTS <= P0_GRANTS + 16'd1;
                end
                STARVED <= forced;
            end
        end
    end
`endif

endmodule
